// File: rtl/apb4_req_master.sv
// APB4 initiator: accepts one valid/ready request, runs a SETUP/ACCESS transfer,
// and returns read data plus error/timeout status on a valid/ready response channel.
module apb4_req_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [3:0]            req_wstrb_i,
    input  logic [2:0]            req_prot_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0] apb_paddr_o,
    output logic [2:0]            apb_pprot_o,
    output logic                  apb_psel_o,
    output logic                  apb_penable_o,
    output logic                  apb_pwrite_o,
    output logic [DATA_WIDTH-1:0] apb_pwdata_o,
    output logic [3:0]            apb_pstrb_o,
    input  logic [DATA_WIDTH-1:0] apb_prdata_i,
    input  logic                  apb_pready_i,
    input  logic                  apb_pslverr_i
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [3:0]            pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  timeout_q, timeout_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    paddr_d  = req_addr_i;
                    pwrite_d = req_write_i;
                    pwdata_d = req_wdata_i;
                    pstrb_d  = req_write_i ? req_wstrb_i : 4'h0;
                    pprot_d  = req_prot_i;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // PREADY takes priority over a timeout reached in the same cycle.
                if (apb_pready_i) begin
                    rdata_d   = pwrite_q ? '0 : apb_prdata_i;
                    err_d     = apb_pslverr_i;
                    timeout_d = 1'b0;
                    state_d   = S_RESP;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus strobes decode straight from the state flop so reset drops them at once.
    assign req_ready_o   = (state_q == S_IDLE);
    assign rsp_valid_o   = (state_q == S_RESP);
    assign apb_psel_o    = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign apb_penable_o = (state_q == S_ACCESS);
    assign apb_paddr_o   = paddr_q;
    assign apb_pwrite_o  = pwrite_q;
    assign apb_pwdata_o  = pwdata_q;
    assign apb_pstrb_o   = pstrb_q;
    assign apb_pprot_o   = pprot_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = timeout_q;

endmodule

// File: tb/tb_apb4_req_master.sv
// Directed bench for apb4_req_master: each task drives one scenario cycle by cycle
// and compares outputs 1ns after the rising edge against hand-computed values.
`timescale 1ns/1ps
module tb_apb4_req_master;

    localparam int AW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          req_write = 1'b0;
    logic [31:0]   req_wdata = '0;
    logic [3:0]    req_wstrb = '0;
    logic [2:0]    req_prot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [31:0]   prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    apb4_req_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .req_prot_i(req_prot),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .apb_paddr_o(paddr), .apb_pprot_o(pprot), .apb_psel_o(psel),
        .apb_penable_o(penable), .apb_pwrite_o(pwrite), .apb_pwdata_o(pwdata),
        .apb_pstrb_o(pstrb), .apb_prdata_i(prdata), .apb_pready_i(pready),
        .apb_pslverr_i(pslverr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        req_prot  = prot;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({req_ready, rsp_valid, psel, penable, pwrite} !== 5'b10000)
            $display("FAIL reset_flags_in_reset: got %b expected %b",
                     {req_ready, rsp_valid, psel, penable, pwrite}, 5'b10000);
        else passed++;
        rst = 1'b0;
        tick();
        total++;
        if ({paddr, pwdata, pstrb, pprot} !== 71'd0)
            $display("FAIL reset_bus_regs: got %h expected 0", {paddr, pwdata, pstrb, pprot});
        else passed++;
        total++;
        if ({rsp_rdata, rsp_err, rsp_timeout, req_ready, rsp_valid} !== {32'h0, 4'b0010})
            $display("FAIL reset_rsp_regs: got %h expected %h",
                     {rsp_rdata, rsp_err, rsp_timeout, req_ready, rsp_valid}, {32'h0, 4'b0010});
        else passed++;
    endtask

    task automatic test_read();
        start_req(1'b0, 32'h0, 32'h1111_2222, 4'hF, 3'b101);
        pready = 1'b1; prdata = 32'h0000_00FF; pslverr = 1'b0;
        total++;
        if (req_ready !== 1'b1) $display("FAIL read_accept_ready: got %b expected 1", req_ready);
        else passed++;
        tick();
        req_valid = 1'b0;
        total++;
        if ({psel, penable, rsp_valid, req_ready} !== 4'b1000)
            $display("FAIL read_setup: got %b expected 1000", {psel, penable, rsp_valid, req_ready});
        else passed++;
        total++;
        if ({paddr, pwrite, pstrb, pprot} !== {32'h0, 1'b0, 4'h0, 3'b101})
            $display("FAIL read_setup_ctrl: got %h expected %h",
                     {paddr, pwrite, pstrb, pprot}, {32'h0, 1'b0, 4'h0, 3'b101});
        else passed++;
        tick();
        total++;
        if ({psel, penable, rsp_valid, req_ready} !== 4'b1100)
            $display("FAIL read_access: got %b expected 1100", {psel, penable, rsp_valid, req_ready});
        else passed++;
        tick();
        total++;
        if ({psel, penable, rsp_valid, req_ready} !== 4'b0010)
            $display("FAIL read_resp_flags: got %b expected 0010", {psel, penable, rsp_valid, req_ready});
        else passed++;
        total++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {32'h0000_00FF, 2'b00})
            $display("FAIL read_resp_data: got %h expected %h",
                     {rsp_rdata, rsp_err, rsp_timeout}, {32'h0000_00FF, 2'b00});
        else passed++;
        tick();
        total++;
        if ({psel, penable, rsp_valid, req_ready} !== 4'b0001)
            $display("FAIL read_back_idle: got %b expected 0001", {psel, penable, rsp_valid, req_ready});
        else passed++;
    endtask

    task automatic test_write();
        pready = 1'b0; prdata = 32'h1234_5678;
        start_req(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 3'b000);
        tick();
        req_valid = 1'b0;
        total++;
        if ({psel, penable, paddr, pwrite, pwdata, pstrb} !== {2'b10, 32'h4, 1'b1, 32'hDEAD_BEEF, 4'hF})
            $display("FAIL write_setup_ctrl: got %h expected %h", {psel, penable, paddr, pwrite, pwdata, pstrb},
                     {2'b10, 32'h4, 1'b1, 32'hDEAD_BEEF, 4'hF});
        else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({psel, penable, paddr, pwdata, pstrb} !== {2'b11, 32'h4, 32'hDEAD_BEEF, 4'hF})
                $display("FAIL write_access_stable[%0d]: got %h expected %h", i,
                         {psel, penable, paddr, pwdata, pstrb}, {2'b11, 32'h4, 32'hDEAD_BEEF, 4'hF});
            else passed++;
            if (i == 3) pready = 1'b1;
        end
        tick();
        total++;
        if ({rsp_valid, psel, rsp_rdata, rsp_err, rsp_timeout} !== {2'b10, 32'h0, 2'b00})
            $display("FAIL write_resp: got %h expected %h",
                     {rsp_valid, psel, rsp_rdata, rsp_err, rsp_timeout}, {2'b10, 32'h0, 2'b00});
        else passed++;
        tick();
        pready = 1'b0;
    endtask

    task automatic test_slverr();
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFE_0001;
        start_req(1'b0, 32'h8, 32'h0, 4'hF, 3'b000);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        total++;
        if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, 32'hCAFE_0001, 2'b10})
            $display("FAIL slverr_resp: got %h expected %h",
                     {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, 32'hCAFE_0001, 2'b10});
        else passed++;
        tick();
        // PSLVERR raised while PREADY is low must not stick.
        pready = 1'b0; pslverr = 1'b1;
        start_req(1'b0, 32'hC, 32'h0, 4'hF, 3'b000);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        total++;
        if ({psel, penable, rsp_valid} !== 3'b110)
            $display("FAIL slverr_wait_access: got %b expected 110", {psel, penable, rsp_valid});
        else passed++;
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0BAD_0000;
        tick();
        total++;
        if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, 32'h0BAD_0000, 2'b00})
            $display("FAIL slverr_ignored: got %h expected %h",
                     {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, 32'h0BAD_0000, 2'b00});
        else passed++;
        tick();
        pready = 1'b0;
    endtask

    task automatic test_timeout();
        pready = 1'b0; prdata = 32'hAAAA_5555;
        start_req(1'b0, 32'h20, 32'h0, 4'hF, 3'b000);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            tick();
            total++;
            if ({psel, penable, rsp_valid} !== 3'b110)
                $display("FAIL timeout_access[%0d]: got %b expected 110", i, {psel, penable, rsp_valid});
            else passed++;
        end
        tick();
        total++;
        if ({psel, penable, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {3'b001, 32'h0, 2'b11})
            $display("FAIL timeout_resp: got %h expected %h",
                     {psel, penable, rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {3'b001, 32'h0, 2'b11});
        else passed++;
        tick();
        pready = 1'b1; prdata = 32'h0000_0055;
        start_req(1'b0, 32'h24, 32'h0, 4'hF, 3'b000);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        total++;
        if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, 32'h55, 2'b00})
            $display("FAIL timeout_recover: got %h expected %h",
                     {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, 32'h55, 2'b00});
        else passed++;
        tick();
        pready = 1'b0; prdata = 32'h0000_0077;
        start_req(1'b0, 32'h28, 32'h0, 4'hF, 3'b000);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            tick();
            if (i == TO - 1) pready = 1'b1;
        end
        tick();
        total++;
        if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, 32'h77, 2'b00})
            $display("FAIL timeout_pready_wins: got %h expected %h",
                     {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, 32'h77, 2'b00});
        else passed++;
        tick();
        pready = 1'b0;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0; pready = 1'b1; prdata = 32'h0000_0099;
        start_req(1'b0, 32'h14, 32'h0, 4'hF, 3'b000);
        tick();
        req_addr = 32'h18;
        tick();
        tick();
        prdata = 32'h0000_1234;
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({rsp_valid, req_ready, rsp_rdata} !== {2'b10, 32'h99})
                $display("FAIL bp_hold[%0d]: got %h expected %h", i,
                         {rsp_valid, req_ready, rsp_rdata}, {2'b10, 32'h99});
            else passed++;
            if (i == 5) rsp_ready = 1'b1;
            else tick();
        end
        tick();
        total++;
        if ({req_ready, rsp_valid} !== 2'b10)
            $display("FAIL bp_accept_ready: got %b expected 10", {req_ready, rsp_valid});
        else passed++;
        tick();
        req_valid = 1'b0; prdata = 32'h0000_0042;
        total++;
        if ({psel, penable, paddr} !== {2'b10, 32'h18})
            $display("FAIL bp_next_setup: got %h expected %h", {psel, penable, paddr}, {2'b10, 32'h18});
        else passed++;
        tick();
        tick();
        total++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h42})
            $display("FAIL bp_next_resp: got %h expected %h", {rsp_valid, rsp_rdata}, {1'b1, 32'h42});
        else passed++;
        tick();
        pready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] sel_seq;
        logic [7:0] rdy_seq;
        rsp_ready = 1'b1; pready = 1'b1; prdata = 32'h0000_0011;
        start_req(1'b0, 32'h40, 32'h0, 4'hF, 3'b000);
        for (int i = 0; i < 8; i++) begin
            tick();
            sel_seq[7-i] = psel;
            rdy_seq[7-i] = req_ready;
        end
        req_valid = 1'b0;
        total++;
        if (sel_seq !== 8'b1100_1100)
            $display("FAIL b2b_psel_pattern: got %b expected 11001100", sel_seq);
        else passed++;
        total++;
        if (rdy_seq !== 8'b0001_0001)
            $display("FAIL b2b_ready_pattern: got %b expected 00010001", rdy_seq);
        else passed++;
        tick();
        pready = 1'b0;
    endtask

    task automatic test_reset_mid();
        pready = 1'b0;
        start_req(1'b0, 32'h30, 32'h0, 4'hF, 3'b000);
        tick();
        req_valid = 1'b0;
        tick();
        total++;
        if ({psel, penable} !== 2'b11)
            $display("FAIL rst_mid_pre_access: got %b expected 11", {psel, penable});
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({psel, penable, rsp_valid, req_ready} !== 4'b0001)
            $display("FAIL rst_mid_async: got %b expected 0001", {psel, penable, rsp_valid, req_ready});
        else passed++;
        #4;
        rst = 1'b0;
        tick();
        total++;
        if ({psel, penable, rsp_valid, req_ready} !== 4'b0001)
            $display("FAIL rst_mid_after: got %b expected 0001", {psel, penable, rsp_valid, req_ready});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_slverr();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
